hazard_controller: RTL and testbench
====================================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, max cycles spent waiting for i_mem_ack before forced release (range 2..255).
REQ-002 SHALL have ports: i_clk in 1, sole clock, rising edge; i_reset in 1, synchronous, active-high.
REQ-003 SHALL have ports: i_rs1_addr_decode, i_rs2_addr_decode in 5, source regs in ID; i_rs1_used_decode, i_rs2_used_decode in 1, source actually read.
REQ-004 SHALL have ports: i_rs1_addr_execute, i_rs2_addr_execute in 5; i_rd_addr_execute in 5; i_rd_wren_execute in 1; i_is_load_execute in 1.
REQ-005 SHALL have ports: i_rd_addr_memory in 5, i_rd_wren_memory in 1, i_rd_addr_writeback in 5, i_rd_wren_writeback in 1.
REQ-006 SHALL have ports: i_mispred_execute in 1, branch/jump in EX resolved taken (predicted untaken); i_mem_req_memory in 1, load/store in MEM; i_mem_ack in 1, memory done this cycle.
REQ-007 SHALL have ports: o_stall_fetch, o_stall_decode, o_stall_execute, o_stall_memory out 1, hold pipeline register; o_flush_decode, o_flush_execute, o_flush_writeback out 1, load bubble (insn_vld=0, rd_wren=0).
REQ-008 SHALL have ports: o_fwd_a_sel, o_fwd_b_sel out 2, operand source for EX (00 regfile, 01 MEM-stage ALU/PC+4 data, 10 WB data); o_mem_timeout out 1, one-cycle pulse on forced release.

Function
REQ-009 Forwarding SHALL be combinational: sel=01 if i_rd_wren_memory and rd_memory==rs_execute!=0; else 10 if i_rd_wren_writeback and rd_writeback==rs_execute!=0; else 00.
REQ-010 Register x0 SHALL never cause a hazard or forward.
REQ-011 Load-use SHALL be detected when i_is_load_execute, i_rd_wren_execute, rd_execute!=0, and it matches a used decode source; response: stall fetch+decode, flush execute, for exactly one cycle per occurrence.
REQ-012 Mispredict (i_mispred_execute) SHALL flush decode and execute in the same cycle with no stall; mispredict overrides load-use (load-use stall suppressed).
REQ-013 Memory-wait FSM SHALL have states RUN and MEM_WAIT with an 8-bit wait counter.
REQ-014 RUN->MEM_WAIT when i_mem_req_memory && !i_mem_ack; counter cleared to 0.
REQ-015 MEM_WAIT: counter increments each cycle; ->RUN on i_mem_ack, or on counter==MEM_TIMEOUT-1 (timeout_hit).
REQ-016 mem_stall = i_mem_req_memory && !i_mem_ack && !timeout_hit; when set, SHALL assert all four stalls and o_flush_writeback; all other flushes SHALL be 0.
REQ-017 mem_stall SHALL take priority over mispredict and load-use; a mispredict held in EX during mem_stall SHALL be applied on the first cycle after release.
REQ-018 o_mem_timeout SHALL be 1 exactly in the cycle timeout_hit is true.
REQ-019 i_mem_ack arriving in the same cycle as i_mem_req_memory SHALL cause no stall and no state change.
REQ-020 All stall/flush/forward outputs SHALL be combinational from inputs and registered state (zero-cycle latency).

Reset
REQ-021 While i_reset is high, all stall/flush outputs and o_mem_timeout SHALL be 0 and forwarding selects 00.
REQ-022 On a clock edge with i_reset high, FSM SHALL go to RUN and counter to 0, including mid-MEM_WAIT.

Configuration
REQ-023 With HAZARD_PERF_CNT_EN defined, SHALL add outputs o_stall_count and o_flush_count (32-bit), counting cycles with any stall and cycles with any flush, cleared on reset, wrapping 0xFFFFFFFF->0.
REQ-024 Without HAZARD_PERF_CNT_EN, those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-025 Package hazard_pkg SHALL hold the fwd_sel_e enum (FWD_RF, FWD_MEM, FWD_WB), the mem_state_e enum (RUN, MEM_WAIT) and the MEM_TIMEOUT default.
REQ-026 The memory-wait FSM and counter SHALL be sub-module hazard_mem_wait_fsm; detection and forwarding logic SHALL stay in the top module.

Verification
REQ-027 Load x5 in EX, decode rs1=x5 used -> one cycle o_stall_fetch=o_stall_decode=o_flush_execute=1, next cycle all 0.
REQ-028 rd_memory=x3 wren=1, rd_writeback=x3 wren=1, rs1_execute=x3 -> o_fwd_a_sel=01; rs1_execute=x0 with rd=x0 -> 00.
REQ-029 Load in EX matching decode plus i_mispred_execute=1 -> o_flush_decode=o_flush_execute=1, o_stall_fetch=0.
REQ-030 i_mem_req_memory=1, ack after 3 cycles -> 3 cycles all stalls + o_flush_writeback=1, release on ack cycle, FSM RUN.
REQ-031 MEM_TIMEOUT=4, ack never -> stalls for 3 cycles, then o_mem_timeout pulse 1 cycle, stalls 0, FSM RUN.
REQ-032 i_reset=1 in 2nd MEM_WAIT cycle -> outputs 0 immediately, FSM RUN and perf counters 0 after edge.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Holds the forwarding-select and memory-wait state encodings, the default
// memory-acknowledge timeout, and the bypass priority rule.
package hazard_pkg;

  localparam int MEM_TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

  // The youngest producer (MEM) wins over WB; x0 is never a producer.
  function automatic fwd_sel_e fwd_select(
    input logic [4:0] rs,
    input logic [4:0] rd_mem,
    input logic       wren_mem,
    input logic [4:0] rd_wb,
    input logic       wren_wb
  );
    if (wren_mem && (rd_mem != 5'd0) && (rd_mem == rs)) return FWD_MEM;
    if (wren_wb && (rd_wb != 5'd0) && (rd_wb == rs)) return FWD_WB;
    return FWD_RF;
  endfunction

  // A decode source collides with a destination only when it is really read.
  function automatic logic src_match(
    input logic [4:0] rs,
    input logic       used,
    input logic [4:0] rd
  );
    return used && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_mem_wait_fsm.sv
// Memory-wait tracker for the hazard controller.
// count is the number of cycles the current access has been stalled; the RUN
// cycle that first sees the request un-acked is cycle 0, so the first MEM_WAIT
// cycle sees count=1. timeout_hit is registered: it is computed one edge ahead
// so it is true exactly while count == MEM_TIMEOUT-1 in MEM_WAIT.
module hazard_mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_req,
  input  logic mem_ack,
  output logic timeout_hit
);

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  mem_state_e state;
  logic [7:0] count;

  // State, wait counter and look-ahead timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      count       <= 8'd0;
      timeout_hit <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_req && !mem_ack) begin
            state       <= MEM_WAIT;
            count       <= 8'd1;
            timeout_hit <= (TMO_LAST == 8'd1);
          end else begin
            count       <= 8'd0;
            timeout_hit <= 1'b0;
          end
        end
        MEM_WAIT: begin
          if (mem_ack || timeout_hit) begin
            state       <= RUN;
            count       <= 8'd0;
            timeout_hit <= 1'b0;
          end else begin
            count       <= count + 8'd1;
            timeout_hit <= ((count + 8'd1) == TMO_LAST);
          end
        end
        default: begin
          state       <= RUN;
          count       <= 8'd0;
          timeout_hit <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: operand forwarding, load-use interlock,
// mispredict flush and memory-wait stall with forced release on timeout.
// Optional build macro HAZARD_PERF_CNT_EN adds 32-bit stall/flush cycle
// counters (o_stall_count, o_flush_count).
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [4:0]  i_rs1_addr_decode,
  input  logic [4:0]  i_rs2_addr_decode,
  input  logic        i_rs1_used_decode,
  input  logic        i_rs2_used_decode,
  input  logic [4:0]  i_rs1_addr_execute,
  input  logic [4:0]  i_rs2_addr_execute,
  input  logic [4:0]  i_rd_addr_execute,
  input  logic        i_rd_wren_execute,
  input  logic        i_is_load_execute,
  input  logic [4:0]  i_rd_addr_memory,
  input  logic        i_rd_wren_memory,
  input  logic [4:0]  i_rd_addr_writeback,
  input  logic        i_rd_wren_writeback,
  input  logic        i_mispred_execute,
  input  logic        i_mem_req_memory,
  input  logic        i_mem_ack,
  output logic        o_stall_fetch,
  output logic        o_stall_decode,
  output logic        o_stall_execute,
  output logic        o_stall_memory,
  output logic        o_flush_decode,
  output logic        o_flush_execute,
  output logic        o_flush_writeback,
  output logic [1:0]  o_fwd_a_sel,
  output logic [1:0]  o_fwd_b_sel,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] o_stall_count,
  output logic [31:0] o_flush_count,
`endif
  output logic        o_mem_timeout
);

  logic     timeout_hit;
  logic     mem_stall;
  logic     load_use;
  fwd_sel_e fwd_a;
  fwd_sel_e fwd_b;

  hazard_mem_wait_fsm #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_fsm (
    .clk         (i_clk),
    .reset       (i_reset),
    .mem_req     (i_mem_req_memory),
    .mem_ack     (i_mem_ack),
    .timeout_hit (timeout_hit)
  );

  // Hazard detection: load-use against the decode sources, memory stall, bypass.
  always_comb begin
    load_use  = i_is_load_execute && i_rd_wren_execute && (i_rd_addr_execute != 5'd0) &&
                (src_match(i_rs1_addr_decode, i_rs1_used_decode, i_rd_addr_execute) ||
                 src_match(i_rs2_addr_decode, i_rs2_used_decode, i_rd_addr_execute));
    mem_stall = i_mem_req_memory && !i_mem_ack && !timeout_hit;
    fwd_a     = fwd_select(i_rs1_addr_execute, i_rd_addr_memory, i_rd_wren_memory,
                           i_rd_addr_writeback, i_rd_wren_writeback);
    fwd_b     = fwd_select(i_rs2_addr_execute, i_rd_addr_memory, i_rd_wren_memory,
                           i_rd_addr_writeback, i_rd_wren_writeback);
  end

  // Response priority: reset, then memory stall, then mispredict, then load-use.
  // A mispredict held in EX during a memory stall simply takes effect on the
  // first cycle the stall drops, since everything here is combinational.
  always_comb begin
    o_stall_fetch     = 1'b0;
    o_stall_decode    = 1'b0;
    o_stall_execute   = 1'b0;
    o_stall_memory    = 1'b0;
    o_flush_decode    = 1'b0;
    o_flush_execute   = 1'b0;
    o_flush_writeback = 1'b0;
    o_mem_timeout     = 1'b0;
    o_fwd_a_sel       = FWD_RF;
    o_fwd_b_sel       = FWD_RF;
    if (!i_reset) begin
      o_fwd_a_sel   = fwd_a;
      o_fwd_b_sel   = fwd_b;
      o_mem_timeout = timeout_hit;
      if (mem_stall) begin
        o_stall_fetch     = 1'b1;
        o_stall_decode    = 1'b1;
        o_stall_execute   = 1'b1;
        o_stall_memory    = 1'b1;
        o_flush_writeback = 1'b1;
      end else if (i_mispred_execute) begin
        o_flush_decode  = 1'b1;
        o_flush_execute = 1'b1;
      end else if (load_use) begin
        o_stall_fetch   = 1'b1;
        o_stall_decode  = 1'b1;
        o_flush_execute = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic any_stall;
  logic any_flush;

  assign any_stall = o_stall_fetch | o_stall_decode | o_stall_execute | o_stall_memory;
  assign any_flush = o_flush_decode | o_flush_execute | o_flush_writeback;

  // Free-running cycle counters; they wrap naturally at 32 bits.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_stall_count <= 32'd0;
      o_flush_count <= 32'd0;
    end else begin
      if (any_stall) o_stall_count <= o_stall_count + 32'd1;
      if (any_flush) o_flush_count <= o_flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: fixed vector table, multi-cycle corner
// sequences, and randomized traffic against a behavioural model.
module tb_hazard_controller;
  import hazard_pkg::*;

  typedef struct packed {
    logic [4:0] rs1_d;
    logic [4:0] rs2_d;
    logic       u1;
    logic       u2;
    logic [4:0] rs1_e;
    logic [4:0] rs2_e;
    logic [4:0] rd_e;
    logic       wren_e;
    logic       load_e;
    logic [4:0] rd_m;
    logic       wren_m;
    logic [4:0] rd_w;
    logic       wren_w;
    logic       mispred;
    logic       req;
    logic       ack;
  } in_t;

  typedef struct {
    in_t        in;
    logic [11:0] exp;
  } vec_t;

  // Packed output word: {sf,sd,se,sm, fd,fe,fw, timeout, fwd_a[1:0], fwd_b[1:0]}
  localparam logic [11:0] MEMSTALL = 12'hF20;
  localparam logic [11:0] LOADUSE  = 12'hC40;
  localparam logic [11:0] MISPRED  = 12'h0C0;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] rs1_addr_decode, rs2_addr_decode, rs1_addr_execute, rs2_addr_execute;
  logic [4:0] rd_addr_execute, rd_addr_memory, rd_addr_writeback;
  logic rs1_used_decode, rs2_used_decode, rd_wren_execute, is_load_execute;
  logic rd_wren_memory, rd_wren_writeback, mispred_execute, mem_req_memory, mem_ack;

  logic sf, sd, se, sm, fd, fe, fw, tmo;
  logic [1:0] fa, fb;
  logic t_sf, t_sd, t_se, t_sm, t_fd, t_fe, t_fw, t_tmo;
  logic [1:0] t_fa, t_fb;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_count, flush_count, t_stall_count, t_flush_count;
`endif

  logic [11:0] act, t_act;
  assign act   = {sf, sd, se, sm, fd, fe, fw, tmo, fa, fb};
  assign t_act = {t_sf, t_sd, t_se, t_sm, t_fd, t_fe, t_fw, t_tmo, t_fa, t_fb};

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hazard_controller dut (
    .i_clk(clk), .i_reset(reset),
    .i_rs1_addr_decode(rs1_addr_decode), .i_rs2_addr_decode(rs2_addr_decode),
    .i_rs1_used_decode(rs1_used_decode), .i_rs2_used_decode(rs2_used_decode),
    .i_rs1_addr_execute(rs1_addr_execute), .i_rs2_addr_execute(rs2_addr_execute),
    .i_rd_addr_execute(rd_addr_execute), .i_rd_wren_execute(rd_wren_execute),
    .i_is_load_execute(is_load_execute),
    .i_rd_addr_memory(rd_addr_memory), .i_rd_wren_memory(rd_wren_memory),
    .i_rd_addr_writeback(rd_addr_writeback), .i_rd_wren_writeback(rd_wren_writeback),
    .i_mispred_execute(mispred_execute), .i_mem_req_memory(mem_req_memory), .i_mem_ack(mem_ack),
    .o_stall_fetch(sf), .o_stall_decode(sd), .o_stall_execute(se), .o_stall_memory(sm),
    .o_flush_decode(fd), .o_flush_execute(fe), .o_flush_writeback(fw),
    .o_fwd_a_sel(fa), .o_fwd_b_sel(fb),
`ifdef HAZARD_PERF_CNT_EN
    .o_stall_count(stall_count), .o_flush_count(flush_count),
`endif
    .o_mem_timeout(tmo)
  );

  hazard_controller #(.MEM_TIMEOUT(4)) dut_t4 (
    .i_clk(clk), .i_reset(reset),
    .i_rs1_addr_decode(rs1_addr_decode), .i_rs2_addr_decode(rs2_addr_decode),
    .i_rs1_used_decode(rs1_used_decode), .i_rs2_used_decode(rs2_used_decode),
    .i_rs1_addr_execute(rs1_addr_execute), .i_rs2_addr_execute(rs2_addr_execute),
    .i_rd_addr_execute(rd_addr_execute), .i_rd_wren_execute(rd_wren_execute),
    .i_is_load_execute(is_load_execute),
    .i_rd_addr_memory(rd_addr_memory), .i_rd_wren_memory(rd_wren_memory),
    .i_rd_addr_writeback(rd_addr_writeback), .i_rd_wren_writeback(rd_wren_writeback),
    .i_mispred_execute(mispred_execute), .i_mem_req_memory(mem_req_memory), .i_mem_ack(mem_ack),
    .o_stall_fetch(t_sf), .o_stall_decode(t_sd), .o_stall_execute(t_se), .o_stall_memory(t_sm),
    .o_flush_decode(t_fd), .o_flush_execute(t_fe), .o_flush_writeback(t_fw),
    .o_fwd_a_sel(t_fa), .o_fwd_b_sel(t_fb),
`ifdef HAZARD_PERF_CNT_EN
    .o_stall_count(t_stall_count), .o_flush_count(t_flush_count),
`endif
    .o_mem_timeout(t_tmo)
  );

  task automatic drive(input in_t v, input bit rst);
    reset             = rst;
    rs1_addr_decode   = v.rs1_d;
    rs2_addr_decode   = v.rs2_d;
    rs1_used_decode   = v.u1;
    rs2_used_decode   = v.u2;
    rs1_addr_execute  = v.rs1_e;
    rs2_addr_execute  = v.rs2_e;
    rd_addr_execute   = v.rd_e;
    rd_wren_execute   = v.wren_e;
    is_load_execute   = v.load_e;
    rd_addr_memory    = v.rd_m;
    rd_wren_memory    = v.wren_m;
    rd_addr_writeback = v.rd_w;
    rd_wren_writeback = v.wren_w;
    mispred_execute   = v.mispred;
    mem_req_memory    = v.req;
    mem_ack           = v.ack;
  endtask

  task automatic check12(input string name, input logic [11:0] got, input logic [11:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %03h, want %03h", name, got, want);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Behavioural expectation of the combinational outputs for one cycle.
  function automatic logic [11:0] expect_out(input in_t v, input bit rst, input bit to);
    logic [11:0] r;
    logic ms, lu;
    int a, b;
    r  = 12'h000;
    ms = v.req && !v.ack && !to;
    lu = v.load_e && v.wren_e && (v.rd_e != 0) &&
         ((v.u1 && v.rs1_d == v.rd_e) || (v.u2 && v.rs2_d == v.rd_e));
    if (rst) return 12'h000;
    a = (v.wren_m && v.rd_m != 0 && v.rd_m == v.rs1_e) ? 1 :
        (v.wren_w && v.rd_w != 0 && v.rd_w == v.rs1_e) ? 2 : 0;
    b = (v.wren_m && v.rd_m != 0 && v.rd_m == v.rs2_e) ? 1 :
        (v.wren_w && v.rd_w != 0 && v.rd_w == v.rs2_e) ? 2 : 0;
    r[3:2] = 2'(a);
    r[1:0] = 2'(b);
    r[4]   = to;
    if (ms)             r[11:5] = 7'b1111_001;
    else if (v.mispred) r[7:6]  = 2'b11;
    else if (lu)        r[11:10] = 2'b11;
    if (!ms && !v.mispred && lu) r[6] = 1'b1;
    return r;
  endfunction

  vec_t tbl[$];

  task automatic add(input in_t v, input logic [11:0] e);
    vec_t t;
    t.in  = v;
    t.exp = e;
    tbl.push_back(t);
  endtask

  initial begin
    in_t v, z;
    bit  rst, to, m_wait;
    int  m_age;
    logic [11:0] e;
    logic [31:0] m_sc, m_fc;

    z = '0;

    // Table: each row is one cycle starting from RUN with no memory stall.
    add(z, 12'h000);
    v = z; v.load_e = 1; v.wren_e = 1; v.rd_e = 5; v.rs1_d = 5; v.u1 = 1; add(v, LOADUSE);
    v.u1 = 0; add(v, 12'h000);
    v = z; v.load_e = 1; v.wren_e = 1; v.rd_e = 0; v.rs1_d = 0; v.u1 = 1; add(v, 12'h000);
    v = z; v.load_e = 1; v.wren_e = 1; v.rd_e = 7; v.rs2_d = 7; v.u2 = 1; add(v, LOADUSE);
    v.wren_e = 0; add(v, 12'h000);
    v.wren_e = 1; v.load_e = 0; add(v, 12'h000);
    v.load_e = 1; v.mispred = 1; add(v, MISPRED);
    v = z; v.mispred = 1; add(v, MISPRED);
    v = z; v.rd_m = 3; v.wren_m = 1; v.rd_w = 3; v.wren_w = 1; v.rs1_e = 3; add(v, 12'h004);
    v = z; v.wren_m = 1; v.wren_w = 1; add(v, 12'h000);
    v = z; v.rd_m = 3; v.rd_w = 3; v.wren_w = 1; v.rs1_e = 3; v.rs2_e = 3; add(v, 12'h00A);
    v = z; v.rd_m = 4; v.wren_m = 1; v.rs2_e = 4; v.rd_w = 9; v.wren_w = 1; v.rs1_e = 9; add(v, 12'h009);
    v = z; v.req = 1; v.ack = 1; add(v, 12'h000);
    add(z, 12'h000);

    // Reset state, with hazards on the inputs that must be masked.
    v = z; v.req = 1; v.mispred = 1; v.rd_m = 3; v.wren_m = 1; v.rs1_e = 3;
    drive(v, 1'b1);
    @(negedge clk);
    check12("reset_outputs", act, 12'h000);
    next_cycle();
    drive(z, 1'b1);
    next_cycle();

    foreach (tbl[i]) begin
      drive(tbl[i].in, 1'b0);
      @(negedge clk);
      check12($sformatf("table[%0d]", i), act, tbl[i].exp);
      next_cycle();
    end

    // Ack after three stalled cycles, with a mispredict and load-use held in EX.
    drive(z, 1'b1); next_cycle();
    v = z; v.req = 1; v.mispred = 1; v.load_e = 1; v.wren_e = 1; v.rd_e = 5; v.rs1_d = 5; v.u1 = 1;
    for (int c = 0; c < 3; c++) begin
      drive(v, 1'b0);
      @(negedge clk);
      check12($sformatf("ack_wait_c%0d", c), act, MEMSTALL);
      next_cycle();
    end
    v.ack = 1;
    drive(v, 1'b0);
    @(negedge clk);
    check12("ack_release_mispred", act, MISPRED);
    next_cycle();
    drive(z, 1'b0);
    @(negedge clk);
    check12("ack_after_idle", act, 12'h000);
    check12("ack_fsm_run", {11'd0, dut.u_mem_fsm.state == RUN}, 12'h001);
    next_cycle();

    // Forced release on the MEM_TIMEOUT=4 instance.
    drive(z, 1'b1); next_cycle();
    v = z; v.req = 1;
    for (int c = 0; c < 3; c++) begin
      drive(v, 1'b0);
      @(negedge clk);
      check12($sformatf("tmo_wait_c%0d", c), t_act, MEMSTALL);
      next_cycle();
    end
    drive(v, 1'b0);
    @(negedge clk);
    check12("tmo_pulse", t_act, 12'h010);
    next_cycle();
    drive(z, 1'b0);
    @(negedge clk);
    check12("tmo_after", t_act, 12'h000);
    check12("tmo_fsm_run", {11'd0, dut_t4.u_mem_fsm.state == RUN}, 12'h001);
    next_cycle();

    // Reset landing in the second MEM_WAIT cycle.
    drive(z, 1'b1); next_cycle();
    v = z; v.req = 1;
    for (int c = 0; c < 2; c++) begin
      drive(v, 1'b0);
      @(negedge clk);
      check12($sformatf("rst_wait_c%0d", c), act, MEMSTALL);
      next_cycle();
    end
    v.mispred = 1; v.rd_m = 3; v.wren_m = 1; v.rs1_e = 3;
    drive(v, 1'b1);
    @(negedge clk);
    check12("rst_mid_wait", act, 12'h000);
    next_cycle();
    drive(z, 1'b0);
    @(negedge clk);
    check12("rst_fsm_run", {11'd0, dut.u_mem_fsm.state == RUN}, 12'h001);
`ifdef HAZARD_PERF_CNT_EN
    check32("rst_stall_count", stall_count, 32'd0);
    check32("rst_flush_count", flush_count, 32'd0);
`endif
    next_cycle();

    // Randomized traffic against the model (default MEM_TIMEOUT).
    drive(z, 1'b1); next_cycle();
    m_wait = 0; m_age = 0; m_sc = 0; m_fc = 0;
    for (int i = 0; i < 800; i++) begin
      v.rs1_d   = 5'($urandom_range(0, 3));
      v.rs2_d   = 5'($urandom_range(0, 3));
      v.u1      = 1'($urandom_range(0, 1));
      v.u2      = 1'($urandom_range(0, 1));
      v.rs1_e   = 5'($urandom_range(0, 3));
      v.rs2_e   = 5'($urandom_range(0, 3));
      v.rd_e    = 5'($urandom_range(0, 3));
      v.wren_e  = 1'($urandom_range(0, 1));
      v.load_e  = 1'($urandom_range(0, 1));
      v.rd_m    = 5'($urandom_range(0, 3));
      v.wren_m  = 1'($urandom_range(0, 1));
      v.rd_w    = 5'($urandom_range(0, 3));
      v.wren_w  = 1'($urandom_range(0, 1));
      v.mispred = ($urandom_range(0, 7) == 0);
      v.req     = ($urandom_range(0, 2) != 0);
      v.ack     = (i < 400) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 24) == 0);
      rst       = ($urandom_range(0, 59) == 0);
      drive(v, rst);
      to = m_wait && (m_age == MEM_TIMEOUT_DEFAULT - 1);
      e  = expect_out(v, rst, to);
      @(negedge clk);
      check12($sformatf("random[%0d]", i), act, e);
`ifdef HAZARD_PERF_CNT_EN
      check32("rand_stall_count", stall_count, m_sc);
      check32("rand_flush_count", flush_count, m_fc);
`endif
      if (rst) begin
        m_wait = 0; m_age = 0; m_sc = 0; m_fc = 0;
      end else begin
        if (|e[11:8]) m_sc = m_sc + 1;
        if (|e[7:5])  m_fc = m_fc + 1;
        if (!m_wait) begin
          if (v.req && !v.ack) begin m_wait = 1; m_age = 1; end
        end else if (v.ack || to) begin
          m_wait = 0; m_age = 0;
        end else begin
          m_age++;
        end
      end
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
